// File: rtl/memory_unit.sv
// Single-port synchronous memory with a streaming boot loader.
// The loader fills the array while the CPU is held in reset; the CPU is then released and served with one-cycle reads.
module memory_unit #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] out,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  cpu_rst_n,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   load_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_PTR = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH:0]   ptr_r;
  logic [DATA_WIDTH-1:0] out_r;
  logic                  ld_ready_r;
  logic                  cpu_rst_n_r;
  logic                  load_done_r;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic                  xfer_s;
  logic                  exit_s;
  logic                  wr_en_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [DATA_WIDTH-1:0] wr_data_s;

  // A load ends on ld_last or on the word that fills the last address, whichever comes first.
  assign xfer_s = (state_r == LOAD) && ld_valid && ld_ready_r;
  assign exit_s = xfer_s && (ld_last || (ptr_r == LAST_PTR));

  // Single write port shared by the loader (LOAD) and the CPU (RUN).
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = {ADDR_WIDTH{1'b0}};
    wr_data_s = {DATA_WIDTH{1'b0}};
    case (state_r)
      LOAD: begin
        if (xfer_s) begin
          wr_en_s   = 1'b1;
          wr_addr_s = ptr_r[ADDR_WIDTH-1:0];
          wr_data_s = ld_data;
        end else begin
          wr_en_s   = 1'b0;
        end
      end
      RUN: begin
        if (we) begin
          wr_en_s   = 1'b1;
          wr_addr_s = addr;
          wr_data_s = data;
        end else begin
          wr_en_s   = 1'b0;
        end
      end
      default: wr_en_s = 1'b0;
    endcase
  end

  // Storage array; deliberately not reset so contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Load/run sequencer with registered handshake, CPU reset and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= LOAD;
      ptr_r       <= {(ADDR_WIDTH + 1){1'b0}};
      out_r       <= {DATA_WIDTH{1'b0}};
      ld_ready_r  <= 1'b0;
      cpu_rst_n_r <= 1'b0;
      load_done_r <= 1'b0;
    end else begin
      case (state_r)
        LOAD: begin
          out_r       <= {DATA_WIDTH{1'b0}};
          cpu_rst_n_r <= 1'b0;
          if (exit_s) begin
            state_r     <= RUN;
            ptr_r       <= ptr_r + PTR_ONE;
            ld_ready_r  <= 1'b0;
            load_done_r <= 1'b1;
          end else if (xfer_s) begin
            ptr_r       <= ptr_r + PTR_ONE;
            ld_ready_r  <= 1'b1;
          end else begin
            ld_ready_r  <= 1'b1;
          end
        end
        RUN: begin
          // Read-first: the array update for this edge is not yet visible here.
          out_r       <= mem_r[addr];
          ld_ready_r  <= 1'b0;
          cpu_rst_n_r <= 1'b1;
          load_done_r <= 1'b1;
        end
        default: begin
          state_r     <= LOAD;
          ld_ready_r  <= 1'b0;
          cpu_rst_n_r <= 1'b0;
        end
      endcase
    end
  end

  assign out       = out_r;
  assign ld_ready  = ld_ready_r;
  assign cpu_rst_n = cpu_rst_n_r;
  assign load_done = load_done_r;
  assign load_cnt  = ptr_r;

endmodule

// File: tb/tb_memory_unit.sv
// Self-checking bench for memory_unit: random loads and CPU traffic against an array model.
module tb_memory_unit;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data = '0;
  logic [DW-1:0] out;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_last = 1'b0;
  logic          ld_ready;
  logic          cpu_rst_n;
  logic          load_done;
  logic [AW:0]   load_cnt;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] model [DEPTH];
  int            m_cnt;

  memory_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .data(data), .out(out),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .cpu_rst_n(cpu_rst_n), .load_done(load_done), .load_cnt(load_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset asynchronously away from an edge, check the reset values, then release.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
    chk("rst_ld_ready", 32'(ld_ready), 32'h0);
    chk("rst_load_done", 32'(load_done), 32'h0);
    chk("rst_load_cnt", 32'(load_cnt), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ld_ready", 32'(ld_ready), 32'h1);
    chk("post_rst_load_done", 32'(load_done), 32'h0);
    m_cnt = 0;
  endtask

  // Stream n words; the CPU port carries random writes that must be ignored.
  task automatic load_words(input int n, input bit use_last, input bit gaps, input bit seq, input logic [DW-1:0] base);
    int  sent;
    int  cycles;
    bit  done;
    bit  exp_ready;
    logic [DW-1:0] word;
    sent = 0;
    cycles = 0;
    done = 1'b0;
    exp_ready = 1'b1;
    while (!done && cycles < 400) begin
      word = seq ? DW'(base + DW'(sent)) : DW'($urandom);
      ld_valid = (sent < n) && (gaps ? ($urandom_range(0, 1) == 1) : 1'b1);
      ld_data = word;
      ld_last = use_last && (sent == n - 1);
      we = 1'b1;
      addr = AW'($urandom);
      data = DW'($urandom);
      tick();
      if (ld_valid && exp_ready) begin
        model[m_cnt] = word;
        m_cnt++;
        sent++;
        if (ld_last || m_cnt == DEPTH) done = 1'b1;
      end
      exp_ready = !done;
      chk("ld_ready", 32'(ld_ready), 32'(exp_ready));
      chk("load_cnt", 32'(load_cnt), 32'(m_cnt));
      chk("load_done", 32'(load_done), 32'(done));
      chk("load_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
      chk("load_out", 32'(out), 32'h0);
      cycles++;
    end
    if (!done) chk("load_timeout", 32'h0, 32'h1);
    // One extra offered word after exit must be refused; CPU comes out of reset now.
    ld_valid = 1'b1;
    ld_data = DW'($urandom);
    ld_last = 1'b0;
    we = 1'b0;
    tick();
    chk("exit_cpu_rst_n", 32'(cpu_rst_n), 32'h1);
    chk("exit_ld_ready", 32'(ld_ready), 32'h0);
    chk("exit_load_cnt", 32'(load_cnt), 32'(m_cnt));
    chk("exit_load_done", 32'(load_done), 32'h1);
    ld_valid = 1'b0;
  endtask

  // One CPU cycle: out after the edge shows the word stored before any write at that edge.
  task automatic cpu_step(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    logic [DW-1:0] exp;
    we = w;
    addr = a;
    data = d;
    exp = model[a];
    tick();
    chk(tag, 32'(out), 32'(exp));
    if (w) model[a] = d;
  endtask

  initial begin
    // Reset state at time zero.
    #1;
    chk("init_out", 32'(out), 32'h0);
    chk("init_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
    chk("init_ld_ready", 32'(ld_ready), 32'h0);
    chk("init_load_cnt", 32'(load_cnt), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    m_cnt = 0;
    chk("first_ld_ready", 32'(ld_ready), 32'h1);

    // Idle with ld_valid low: stays in LOAD.
    for (int i = 0; i < 6; i++) begin
      we = 1'b1;
      addr = AW'(i);
      data = DW'($urandom);
      tick();
      chk("idle_ld_ready", 32'(ld_ready), 32'h1);
      chk("idle_load_done", 32'(load_done), 32'h0);
      chk("idle_load_cnt", 32'(load_cnt), 32'h0);
    end

    // Full 64-word load of random data without ld_last.
    load_words(64, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("full_cnt", 32'(load_cnt), 32'd64);
    for (int i = 0; i < DEPTH; i++) cpu_step(1'b0, AW'(i), 16'h0000, "full_read");
    for (int i = 0; i < 150; i++) cpu_step(1'($urandom), AW'($urandom), DW'($urandom), "rand_ops");

    // Mid-run reset, then 8 words 0x1000.. back-to-back with ld_last.
    do_reset();
    load_words(8, 1'b1, 1'b0, 1'b1, 16'h1000);
    cpu_step(1'b0, 6'd3, 16'h0000, "read_addr3");
    chk("addr3_value", 32'(out), 32'h1003);
    for (int i = 0; i < DEPTH; i++) cpu_step(1'b0, AW'(i), 16'h0000, "after8_read");

    // Read-first on the same address.
    cpu_step(1'b1, 6'd5, 16'hBEEF, "wr5_old");
    cpu_step(1'b0, 6'd5, 16'h0000, "rd5_new");
    chk("beef_value", 32'(out), 32'hBEEF);

    // Loader with gaps.
    do_reset();
    load_words(12, 1'b1, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < DEPTH; i++) cpu_step(1'b0, AW'(i), 16'h0000, "gaps_read");

    // Full load ending with ld_last on word 64: one exit event.
    do_reset();
    load_words(64, 1'b1, 1'b0, 1'b1, 16'h2000);
    chk("full_last_cnt", 32'(load_cnt), 32'd64);
    for (int i = 0; i < 40; i++) cpu_step(1'($urandom), AW'($urandom), DW'($urandom), "rand_ops2");

    // Single-word reload: only mem[0] changes.
    do_reset();
    load_words(1, 1'b1, 1'b0, 1'b1, 16'h7A5C);
    chk("one_cnt", 32'(load_cnt), 32'd1);
    for (int i = 0; i < DEPTH; i++) cpu_step(1'b0, AW'(i), 16'h0000, "one_read");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_unit.md
# memory_unit

Single-port synchronous data/program memory that answers the CPU memory interface (address, write enable, write data in; read data out) with one-cycle read latency. After reset, a built-in loader fills the memory from a streaming valid/ready port while the CPU is held in reset. The block then releases the CPU and serves its reads and writes. It sits between the test harness or program source and the CPU's memory port.

## Interface
Parameters:
- ADDR_WIDTH, 6, address width; depth = 2^ADDR_WIDTH words
- DATA_WIDTH, 16, word width

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- we  input  1  CPU write enable (1 = write, 0 = read)
- addr  input  ADDR_WIDTH  CPU address
- data  input  DATA_WIDTH  CPU write data
- out  output  DATA_WIDTH  read data to CPU (registered)
- ld_valid  input  1  loader word valid
- ld_data  input  DATA_WIDTH  loader word
- ld_last  input  1  marks final loader word; qualified by ld_valid
- ld_ready  output  1  loader may transfer this cycle
- cpu_rst_n  output  1  active-low reset to the CPU, registered
- load_done  output  1  high once loading has finished
- load_cnt  output  ADDR_WIDTH+1  number of words accepted by the loader

## Operation
- Storage: 2^ADDR_WIDTH x DATA_WIDTH array. Contents are not cleared by reset; a reset mid-run keeps existing contents until they are overwritten.
- FSM states: LOAD, RUN.
- Reset (asynchronous) puts the block in LOAD with:
  - out = 0, ld_ready = 0, cpu_rst_n = 0, load_done = 0, load_cnt = 0
  - internal load pointer ptr = 0
- LOAD:
  - ld_ready = 1 from the first clock edge after reset deassertion; it is registered.
  - Transfer = ld_valid && ld_ready. On a transfer, mem[ptr] <= ld_data, ptr++ and load_cnt++.
  - CPU we/addr/data are ignored; out stays 0.
  - LOAD -> RUN on a transfer with ld_last = 1, or on the transfer that writes address 2^ADDR_WIDTH-1 (full, ptr would wrap). On this exit the words are counted in load_cnt, ld_ready drops to 0 and load_done is set to 1.
  - Zero-length load: ld_valid held low keeps the block in LOAD indefinitely. There is no timeout.
- RUN:
  - cpu_rst_n goes to 1 one cycle after the RUN entry (registered). cpu_rst_n stays 0 for the whole LOAD phase.
  - Each cycle: out <= mem[addr].
  - Each cycle with we = 1: mem[addr] <= data.
  - Read-during-write to the same address is read-first: out shows the old word, and the new word is visible on the next read.
  - Loader inputs are ignored; ld_ready = 0; load_cnt is frozen.
- Arithmetic and widths:
  - ptr is ADDR_WIDTH+1 bits, so a full load gives load_cnt = 2^ADDR_WIDTH (64 for the default).
  - addr is used unmodified; there are no out-of-range addresses.
- Simultaneous events:
  - ld_last on the same transfer that fills the memory is a single exit event and is counted once.
  - rst_n assertion overrides everything, in any state.

## Timing
- Read latency: address presented in cycle N gives valid out after edge N+1, usable throughout cycle N+1. This matches the CPU's present-address / consume-data phase pairing.
- Write: committed at the edge where we = 1.
- Loader throughput: 1 word per cycle while ld_valid is held high.
- Last transfer edge E: ld_ready = 0 and load_done = 1 after E; cpu_rst_n = 1 after E+1.
- First CPU-visible read: the address driven in the first cycle after cpu_rst_n rises gives data one cycle later.
- out holds its value when not reloaded. In RUN it is reloaded every cycle, so it tracks the previous cycle's address.

## Test plan
- Reset then load 8 words 0x1000..0x1007 back-to-back with ld_last on the 8th -> load_cnt = 8, load_done = 1, cpu_rst_n rises exactly one cycle after load_done; out = 0 throughout LOAD.
- After that load, drive addr = 3 with we = 0 -> out = 0x1003 on the next cycle; addr = 8..63 return prior contents.
- Loader with gaps (ld_valid toggling 1,0,1) -> only valid cycles are written; load_cnt increments only on transfers.
- Full load of 64 words with no ld_last -> exit after word 64, load_cnt = 64; a 65th ld_valid is ignored (ld_ready = 0).
- RUN: we = 1, addr = 5, data = 0xBEEF, then we = 0, addr = 5 -> the write-cycle out shows the old mem[5], and the next out = 0xBEEF. CPU writes during LOAD leave memory unchanged.
- Assert rst_n mid-RUN -> out = 0, cpu_rst_n = 0, ld_ready = 1 after release. Reload 1 word (ld_last) at mem[0] -> mem[0] is new and mem[1..] keep their old values.
